// File: rtl/conv_weight_store.sv
// conv_weight_store
// Weight memory for the conv controller. DMA beats of DATA_W bits are packed
// into WT_WIDTH-bit words. Each word is written at one (output group, ci group)
// address. Controller reads come back a fixed three cycles after the request.
//
// Optional build feature: define WT_LOAD_CHECKSUM_EN to add the load_checksum
// output. It is a wrapping 32-bit sum over every 32-bit lane of every accepted
// beat.

module conv_weight_store #(
  parameter int WT_ADDR_WIDTH = 12,
  parameter int DATA_W        = 64,
  parameter int WT_WIDTH      = 576,
  parameter int WT_LATENCY    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WT_ADDR_WIDTH-1:0] cfg_load_base,
  input  logic [WT_ADDR_WIDTH:0]   cfg_load_words,
  input  logic                     load_go,
  output logic                     load_busy,
  output logic                     load_done,
  output logic                     wt_data_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     wt_rd_en,
  input  logic [WT_ADDR_WIDTH-1:0] wt_rd_addr,
  output logic [WT_WIDTH-1:0]      wt_rd_data,
  output logic                     wt_rd_valid,
  output logic                     rd_err
`ifdef WT_LOAD_CHECKSUM_EN
  ,output logic [31:0]             load_checksum
`endif
);

  localparam int BEATS   = WT_WIDTH / DATA_W;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DEPTH   = 1 << WT_ADDR_WIDTH;
  localparam int LANES32 = DATA_W / 32;

  localparam logic [BEAT_W-1:0]        LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0]        BEAT_ONE  = BEAT_W'(1);
  localparam logic [WT_ADDR_WIDTH:0]   WORD_ONE  = (WT_ADDR_WIDTH+1)'(1);
  localparam logic [WT_ADDR_WIDTH-1:0] ADDR_ONE  = WT_ADDR_WIDTH'(1);

  // The read pipeline is built for a three-stage latency only, and the beat
  // packing assumes whole 32-bit lanes that tile the word exactly.
  if (WT_LATENCY != 3) begin : g_bad_latency
    $error("conv_weight_store: WT_LATENCY must be 3");
  end
  if ((DATA_W % 32) != 0) begin : g_bad_data_w
    $error("conv_weight_store: DATA_W must be a multiple of 32");
  end
  if ((WT_WIDTH % DATA_W) != 0) begin : g_bad_wt_width
    $error("conv_weight_store: DATA_W must divide WT_WIDTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic                     go_accept;
  logic                     xfer;
  logic                     last_beat;
  logic                     last_word;

  logic [BEAT_W-1:0]        beat_cnt;
  logic [WT_ADDR_WIDTH:0]   word_cnt;
  logic [WT_ADDR_WIDTH:0]   words_q;
  logic [WT_ADDR_WIDTH-1:0] wr_addr;
  logic                     wr_pend;
  logic [WT_WIDTH-1:0]      pack_reg;

  logic [WT_WIDTH-1:0]      mem [DEPTH];
  logic [WT_ADDR_WIDTH-1:0] rd_addr_q;
  logic                     rd_en_q0;
  logic                     rd_en_q1;
  logic [WT_WIDTH-1:0]      rd_q;

  assign xfer      = s_valid & s_ready;
  assign last_beat = (beat_cnt == LAST_BEAT);
  assign last_word = (word_cnt == (words_q - WORD_ONE));

  // State register; rst aborts any load in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next state and the state-decoded handshake outputs.
  always_comb begin
    next_state = state;
    go_accept  = 1'b0;
    s_ready    = 1'b0;
    load_busy  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_go) begin
          go_accept  = 1'b1;
          next_state = (cfg_load_words == '0) ? ST_COMMIT : ST_LOAD;
        end
      end
      ST_LOAD: begin
        s_ready   = 1'b1;
        load_busy = 1'b1;
        if (xfer && last_beat && last_word) next_state = ST_COMMIT;
      end
      ST_COMMIT: begin
        load_busy  = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Load bookkeeping covers the beat/word counters and the write pointer.
  // It also drives the completion flags and the sticky read error.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt      <= '0;
      word_cnt      <= '0;
      words_q       <= '0;
      wr_addr       <= '0;
      wr_pend       <= 1'b0;
      load_done     <= 1'b0;
      wt_data_ready <= 1'b0;
      rd_err        <= 1'b0;
    end else begin
      load_done <= (state == ST_COMMIT);
      wr_pend   <= xfer & last_beat;
      if (state == ST_COMMIT) wt_data_ready <= 1'b1;
      if (wr_pend) wr_addr <= wr_addr + ADDR_ONE;
      if (xfer) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_ONE;
        if (last_beat) word_cnt <= word_cnt + WORD_ONE;
      end
      if (go_accept) begin
        wr_addr       <= cfg_load_base;
        words_q       <= cfg_load_words;
        beat_cnt      <= '0;
        word_cnt      <= '0;
        wt_data_ready <= 1'b0;
      end
      if (wt_rd_en && !wt_data_ready) rd_err <= 1'b1;
      else if (go_accept)             rd_err <= 1'b0;
    end
  end

  // Each accepted beat goes into its lane of the packing register.
  // Beat 0 lands in the lowest lane.
  always_ff @(posedge clk) begin
    if (xfer) begin
      for (int i = 0; i < BEATS; i++) begin
        if (beat_cnt == BEAT_W'(i)) pack_reg[i*DATA_W +: DATA_W] <= s_data;
      end
    end
  end

  // Word memory has one write port and one registered read port.
  // Both access it in the same block, so a same-cycle collision returns the old data.
  always_ff @(posedge clk) begin
    if (wr_pend) mem[wr_addr] <= pack_reg;
    rd_q <= mem[rd_addr_q];
  end

  // Read pipeline: address register, memory read, output register.
  // Data holds its last value between valid pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_q   <= '0;
      rd_en_q0    <= 1'b0;
      rd_en_q1    <= 1'b0;
      wt_rd_valid <= 1'b0;
      wt_rd_data  <= '0;
    end else begin
      rd_addr_q   <= wt_rd_addr;
      rd_en_q0    <= wt_rd_en;
      rd_en_q1    <= rd_en_q0;
      wt_rd_valid <= rd_en_q1;
      if (rd_en_q1) wt_rd_data <= rd_q;
    end
  end

`ifdef WT_LOAD_CHECKSUM_EN
  logic [31:0] beat_sum;

  // Sum the 32-bit lanes of the current input beat.
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES32; i++) begin
      beat_sum = beat_sum + s_data[i*32 +: 32];
    end
  end

  // Running checksum over the accepted beats. It restarts on each accepted go.
  always_ff @(posedge clk) begin
    if (rst)            load_checksum <= '0;
    else if (go_accept) load_checksum <= '0;
    else if (xfer)      load_checksum <= load_checksum + beat_sum;
  end
`endif

endmodule

// File: tb/tb_conv_weight_store.sv
// tb_conv_weight_store
// Directed bench for conv_weight_store. It covers reset, packing and readback,
// address wrap, gapped input, the read-error flag, zero-word loads and reset
// mid-load. With WT_LOAD_CHECKSUM_EN defined it also checks the load checksum.

module tb_conv_weight_store;

  localparam int AW    = 12;
  localparam int DW    = 64;
  localparam int WW    = 576;
  localparam int BEATS = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] cfg_load_base;
  logic [AW:0]   cfg_load_words;
  logic          load_go;
  logic          load_busy;
  logic          load_done;
  logic          wt_data_ready;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          wt_rd_en;
  logic [AW-1:0] wt_rd_addr;
  logic [WW-1:0] wt_rd_data;
  logic          wt_rd_valid;
  logic          rd_err;
`ifdef WT_LOAD_CHECKSUM_EN
  logic [31:0]   load_checksum;
`endif

  int total = 0;
  int bad   = 0;

  conv_weight_store #(
    .WT_ADDR_WIDTH(AW),
    .DATA_W(DW),
    .WT_WIDTH(WW),
    .WT_LATENCY(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_load_base(cfg_load_base),
    .cfg_load_words(cfg_load_words),
    .load_go(load_go),
    .load_busy(load_busy),
    .load_done(load_done),
    .wt_data_ready(wt_data_ready),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .wt_rd_en(wt_rd_en),
    .wt_rd_addr(wt_rd_addr),
    .wt_rd_data(wt_rd_data),
    .wt_rd_valid(wt_rd_valid),
    .rd_err(rd_err)
`ifdef WT_LOAD_CHECKSUM_EN
    ,.load_checksum(load_checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected word built from consecutive beat values starting at first.
  function automatic logic [WW-1:0] packed_word(input int first);
    logic [WW-1:0] w;
    for (int j = 0; j < BEATS; j++) w[j*DW +: DW] = DW'(first + j);
    return w;
  endfunction

  task automatic start_load(input logic [AW-1:0] base, input logic [AW:0] words);
    cfg_load_base  = base;
    cfg_load_words = words;
    load_go        = 1'b1;
    tick();
    load_go        = 1'b0;
  endtask

  task automatic send_beats(input int first, input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      if (gaps) begin
        for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++) begin
          s_valid = 1'b0;
          s_data  = 64'hdead_beef_dead_beef;
          tick();
        end
      end
      s_valid = 1'b1;
      s_data  = DW'(first + i);
      tick();
    end
    s_valid = 1'b0;
  endtask

  // Single read. trace holds wt_rd_valid after edges 1..4; data is taken at
  // edge 3 and again at edge 4, where it should be held.
  task automatic read_word(input logic [AW-1:0] addr, output logic [WW-1:0] data,
                           output logic [WW-1:0] held, output logic [3:0] trace);
    wt_rd_en   = 1'b1;
    wt_rd_addr = addr;
    tick();
    wt_rd_en = 1'b0;
    trace[0] = wt_rd_valid;
    tick();
    trace[1] = wt_rd_valid;
    tick();
    trace[2] = wt_rd_valid;
    data     = wt_rd_data;
    tick();
    trace[3] = wt_rd_valid;
    held     = wt_rd_data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (load_busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy got=%0b want=0", load_busy); end
    total++; if (load_done !== 1'b0) begin bad++; $display("[TB] FAIL rst_done got=%0b want=0", load_done); end
    total++; if (wt_data_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready got=%0b want=0", wt_data_ready); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_s_ready got=%0b want=0", s_ready); end
    total++; if (wt_rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid got=%0b want=0", wt_rd_valid); end
    total++; if (rd_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_rd_err got=%0b want=0", rd_err); end
    total++; if (wt_rd_data !== '0) begin bad++; $display("[TB] FAIL rst_data got=%h want=0", wt_rd_data[63:0]); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_load();
    logic [WW-1:0] d;
    logic [WW-1:0] h;
    logic [3:0]    tr;
    start_load(12'd0, 13'd2);
    total++; if (load_busy !== 1'b1) begin bad++; $display("[TB] FAIL t1_busy got=%0b want=1", load_busy); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL t1_s_ready got=%0b want=1", s_ready); end
    send_beats(0, 2*BEATS, 1'b0);
    total++; if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL t1_commit_s_ready got=%0b want=0", s_ready); end
    total++; if (load_busy !== 1'b1) begin bad++; $display("[TB] FAIL t1_commit_busy got=%0b want=1", load_busy); end
    total++; if (load_done !== 1'b0) begin bad++; $display("[TB] FAIL t1_commit_done got=%0b want=0", load_done); end
    tick();
    total++; if (load_done !== 1'b1) begin bad++; $display("[TB] FAIL t1_done got=%0b want=1", load_done); end
    total++; if (wt_data_ready !== 1'b1) begin bad++; $display("[TB] FAIL t1_ready got=%0b want=1", wt_data_ready); end
    total++; if (load_busy !== 1'b0) begin bad++; $display("[TB] FAIL t1_idle_busy got=%0b want=0", load_busy); end
    tick();
    total++; if (load_done !== 1'b0) begin bad++; $display("[TB] FAIL t1_done_pulse got=%0b want=0", load_done); end
    read_word(12'd0, d, h, tr);
    total++; if (tr !== 4'b0100) begin bad++; $display("[TB] FAIL t1_rd0_timing got=%b want=0100", tr); end
    total++; if (d !== packed_word(0)) begin bad++; $display("[TB] FAIL t1_rd0_data got=%h want=%h", d[127:0], packed_word(0)); end
    total++; if (h !== packed_word(0)) begin bad++; $display("[TB] FAIL t1_rd0_hold got=%h", h[127:0]); end
    read_word(12'd1, d, h, tr);
    total++; if (tr !== 4'b0100) begin bad++; $display("[TB] FAIL t1_rd1_timing got=%b want=0100", tr); end
    total++; if (d !== packed_word(BEATS)) begin bad++; $display("[TB] FAIL t1_rd1_data got=%h", d[127:0]); end
    total++; if (rd_err !== 1'b0) begin bad++; $display("[TB] FAIL t1_rd_err got=%0b want=0", rd_err); end
  endtask

  task automatic test_back_to_back();
    wt_rd_en   = 1'b1;
    wt_rd_addr = 12'd1;
    tick();
    wt_rd_addr = 12'd0;
    tick();
    wt_rd_en = 1'b0;
    tick();
    total++; if (wt_rd_valid !== 1'b1 || wt_rd_data !== packed_word(BEATS)) begin
      bad++; $display("[TB] FAIL b2b_first valid=%0b data=%h", wt_rd_valid, wt_rd_data[63:0]); end
    tick();
    total++; if (wt_rd_valid !== 1'b1 || wt_rd_data !== packed_word(0)) begin
      bad++; $display("[TB] FAIL b2b_second valid=%0b data=%h", wt_rd_valid, wt_rd_data[63:0]); end
    tick();
    total++; if (wt_rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_end got=%0b want=0", wt_rd_valid); end
  endtask

  task automatic test_wrap();
    logic [WW-1:0] d;
    logic [WW-1:0] h;
    logic [3:0]    tr;
    start_load(12'd4095, 13'd2);
    send_beats(100, 2*BEATS, 1'b0);
    tick();
    tick();
    read_word(12'd4095, d, h, tr);
    total++; if (d !== packed_word(100)) begin bad++; $display("[TB] FAIL t2_rd4095 got=%h", d[127:0]); end
    read_word(12'd0, d, h, tr);
    total++; if (d !== packed_word(109)) begin bad++; $display("[TB] FAIL t2_rd0_wrap got=%h", d[127:0]); end
    read_word(12'd1, d, h, tr);
    total++; if (d !== packed_word(BEATS)) begin bad++; $display("[TB] FAIL t2_rd1_untouched got=%h", d[127:0]); end
  endtask

  task automatic test_gappy();
    logic [WW-1:0] d;
    logic [WW-1:0] h;
    logic [3:0]    tr;
    start_load(12'd0, 13'd2);
    send_beats(0, 2*BEATS, 1'b1);
    total++; if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL t3_s_ready_after got=%0b want=0", s_ready); end
    tick();
    total++; if (load_done !== 1'b1) begin bad++; $display("[TB] FAIL t3_done got=%0b want=1", load_done); end
    tick();
    read_word(12'd0, d, h, tr);
    total++; if (d !== packed_word(0)) begin bad++; $display("[TB] FAIL t3_rd0 got=%h", d[127:0]); end
    read_word(12'd1, d, h, tr);
    total++; if (d !== packed_word(BEATS)) begin bad++; $display("[TB] FAIL t3_rd1 got=%h", d[127:0]); end
  endtask

  task automatic test_rd_err();
    logic [WW-1:0] d;
    logic [WW-1:0] h;
    logic [3:0]    tr;
    start_load(12'd10, 13'd1);
    total++; if (wt_data_ready !== 1'b0) begin bad++; $display("[TB] FAIL t4_ready_clr got=%0b want=0", wt_data_ready); end
    read_word(12'd10, d, h, tr);
    total++; if (tr !== 4'b0100) begin bad++; $display("[TB] FAIL t4_valid_pulse got=%b want=0100", tr); end
    total++; if (rd_err !== 1'b1) begin bad++; $display("[TB] FAIL t4_rd_err_set got=%0b want=1", rd_err); end
    send_beats(200, BEATS, 1'b0);
    tick();
    tick();
    total++; if (rd_err !== 1'b1) begin bad++; $display("[TB] FAIL t4_rd_err_sticky got=%0b want=1", rd_err); end
    read_word(12'd10, d, h, tr);
    total++; if (d !== packed_word(200)) begin bad++; $display("[TB] FAIL t4_rd10 got=%h", d[127:0]); end
    start_load(12'd50, 13'd0);
    total++; if (rd_err !== 1'b0) begin bad++; $display("[TB] FAIL t4_rd_err_clr got=%0b want=0", rd_err); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL t4_zero_s_ready got=%0b want=0", s_ready); end
    total++; if (load_busy !== 1'b1 || load_done !== 1'b0) begin
      bad++; $display("[TB] FAIL t4_zero_commit busy=%0b done=%0b want busy=1 done=0", load_busy, load_done); end
    tick();
    total++; if (load_done !== 1'b1 || wt_data_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL t4_zero_done done=%0b ready=%0b want 1/1", load_done, wt_data_ready); end
    tick();
  endtask

  task automatic test_reset_mid_load();
    logic [WW-1:0] d;
    logic [WW-1:0] h;
    logic [3:0]    tr;
    start_load(12'd20, 13'd2);
    send_beats(300, 4, 1'b0);
    rst = 1'b1;
    tick();
    total++; if (load_busy !== 1'b0 || s_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL t5_fsm busy=%0b s_ready=%0b want 0/0", load_busy, s_ready); end
    total++; if (wt_data_ready !== 1'b0 || load_done !== 1'b0) begin
      bad++; $display("[TB] FAIL t5_flags ready=%0b done=%0b want 0/0", wt_data_ready, load_done); end
    total++; if (wt_rd_data !== '0 || wt_rd_valid !== 1'b0 || rd_err !== 1'b0) begin
      bad++; $display("[TB] FAIL t5_read data=%h valid=%0b err=%0b want 0", wt_rd_data[63:0], wt_rd_valid, rd_err); end
    rst = 1'b0;
    tick();
    start_load(12'd20, 13'd1);
    send_beats(400, BEATS, 1'b0);
    tick();
    total++; if (load_done !== 1'b1 || wt_data_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL t5_reload_done done=%0b ready=%0b want 1/1", load_done, wt_data_ready); end
    tick();
    read_word(12'd20, d, h, tr);
    total++; if (d !== packed_word(400)) begin bad++; $display("[TB] FAIL t5_rd20 got=%h", d[127:0]); end
  endtask

`ifdef WT_LOAD_CHECKSUM_EN
  task automatic test_checksum();
    start_load(12'd30, 13'd1);
    total++; if (load_checksum !== 32'd0) begin bad++; $display("[TB] FAIL t6_clr got=%0d want=0", load_checksum); end
    for (int i = 0; i < BEATS; i++) begin
      s_valid = 1'b1;
      s_data  = 64'h00000001_00000002;
      tick();
    end
    s_valid = 1'b0;
    tick();
    tick();
    total++; if (load_checksum !== 32'd27) begin bad++; $display("[TB] FAIL t6_sum got=%0d want=27", load_checksum); end
  endtask
`endif

  initial begin
    rst            = 1'b1;
    cfg_load_base  = '0;
    cfg_load_words = '0;
    load_go        = 1'b0;
    s_data         = '0;
    s_valid        = 1'b0;
    wt_rd_en       = 1'b0;
    wt_rd_addr     = '0;
    test_reset();
    test_basic_load();
    test_back_to_back();
    test_wrap();
    test_gappy();
    test_rd_err();
    test_reset_mid_load();
`ifdef WT_LOAD_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
